stop_rx: RTL and testbench



---
 rtl/stop_rx_pkg.sv | 14 +
 rtl/stop_rx_comma_detect.sv | 13 +
 rtl/stop_rx.sv | 91 +++++++++
 tb/tb_stop_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/stop_rx_pkg.sv
// rtl/stop_rx_pkg.sv - shared constants and state encoding for the serial byte receiver
package stop_rx_pkg;

  // Idle/alignment symbol, also emitted by the transmitter between data bytes.
  localparam logic [7:0] DEF_COMMA    = 8'hBC;
  localparam int         DEF_BC_COUNT = 4;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/stop_rx_comma_detect.sv
// rtl/stop_rx_comma_detect.sv - combinational match of the candidate word against the comma symbol
module comma_detect
  import stop_rx_pkg::*;
#(
  parameter logic [7:0] COMMA = DEF_COMMA
) (
  input  logic [7:0] word,
  output logic       hit
);

  assign hit = (word == COMMA);

endmodule

// File: rtl/stop_rx.sv
// rtl/stop_rx.sv - MSB-first serial-to-parallel receiver with comma-based byte alignment
module stop_rx
  import stop_rx_pkg::*;
#(
  parameter logic [7:0] COMMA    = DEF_COMMA,
  parameter int         BC_COUNT = DEF_BC_COUNT
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [2:0] BC_TARGET = 3'(BC_COUNT);

  state_t     state;
  // Only seven history bits are ever consulted: the candidate word is history plus the live bit.
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [2:0] bc_cnt;
  logic [7:0] w;
  logic       is_comma;
  logic       boundary;

  assign w        = {sr, in};
  assign boundary = (bit_cnt == 3'd7);

  comma_detect #(.COMMA(COMMA)) u_comma_detect (
    .word (w),
    .hit  (is_comma)
  );

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state     <= ST_SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      out       <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr <= w[6:0];
      case (state)
        ST_SEARCH: begin
          // Any bit phase may start alignment; the matching edge becomes bit 0 of the frame.
          if (is_comma) begin
            bit_cnt <= 3'd0;
            bc_cnt  <= 3'd1;
            if (BC_TARGET == 3'd1) begin
              state  <= ST_ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ST_ALIGN;
            end
          end
        end
        ST_ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_comma) begin
              bc_cnt <= bc_cnt + 3'd1;
              if (bc_cnt + 3'd1 == BC_TARGET) begin
                state  <= ST_ACTIVE;
                active <= 1'b1;
              end
            end else begin
              state  <= ST_SEARCH;
              bc_cnt <= 3'd0;
            end
          end
        end
        ST_ACTIVE: begin
          // Lock is never dropped here; only reset returns to SEARCH.
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            out       <= w;
            valid_out <= !is_comma;
          end
        end
        default: begin
          state  <= ST_SEARCH;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stop_rx.sv
// tb/tb_stop_rx.sv - directed bench with a per-edge expected-output scoreboard for stop_rx
module tb_stop_rx;
  import stop_rx_pkg::*;

  typedef struct {
    logic       act;
    logic [7:0] o;
    logic       v;
    int         tid;
  } exp_t;

  logic       clk32f = 1'b0;
  logic       reset;
  logic       in;
  logic [7:0] out;
  logic       valid_out;
  logic       active;

  exp_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         test_id  = 0;
  logic       cur_act;
  logic [7:0] cur_out;
  logic       cur_v;

  always #5 clk32f = ~clk32f;

  stop_rx dut (
    .clk32f    (clk32f),
    .reset     (reset),
    .in        (in),
    .out       (out),
    .valid_out (valid_out),
    .active    (active)
  );

  task automatic push_exp();
    exp_t e;
    e.act = cur_act;
    e.o   = cur_out;
    e.v   = cur_v;
    e.tid = test_id;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk32f);
    reset = 1'b1;
    in    = b;
    push_exp();
  endtask

  // The LSB edge carries the new expectation; the seven earlier edges expect the held value.
  task automatic send_byte(input logic [7:0] b, input logic ea, input logic [7:0] eo, input logic ev);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    @(negedge clk32f);
    reset   = 1'b1;
    in      = b[0];
    cur_act = ea;
    cur_out = eo;
    cur_v   = ev;
    push_exp();
  endtask

  task automatic send_rep(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_byte(b, cur_act, cur_out, cur_v);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk32f);
      reset   = 1'b0;
      in      = 1'b1;
      cur_act = 1'b0;
      cur_out = 8'h00;
      cur_v   = 1'b0;
      push_exp();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk32f);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (active !== e.act || out !== e.o || valid_out !== e.v) begin
          failures++;
          $display("FAIL test%0d edge: got active=%0b out=%02h valid_out=%0b want active=%0b out=%02h valid_out=%0b",
                   e.tid, active, out, valid_out, e.act, e.o, e.v);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  initial begin : stimulus
    reset   = 1'b0;
    in      = 1'b1;
    cur_act = 1'b0;
    cur_out = 8'h00;
    cur_v   = 1'b0;

    test_id = 0;
    hold_reset(5);

    test_id = 1;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_rep(8'hBC, 3);
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
    send_byte(8'hAA, 1'b1, 8'hAA, 1'b1);
    send_byte(8'hEE, 1'b1, 8'hEE, 1'b1);
    send_byte(8'hEE, 1'b1, 8'hEE, 1'b1);

    test_id = 2;
    send_byte(8'hCC, 1'b1, 8'hCC, 1'b1);
    send_byte(8'hBC, 1'b1, 8'hBC, 1'b0);
    send_byte(8'hBB, 1'b1, 8'hBB, 1'b1);

    test_id = 3;
    hold_reset(3);
    send_rep(8'hBC, 3);
    send_rep(8'hAA, 1);
    send_rep(8'hBC, 3);
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
    send_byte(8'h55, 1'b1, 8'h55, 1'b1);

    // 5E then 00 matches one bit into the 00 byte; that frame is off by seven bits from the
    // following commas, so the first ALIGN check fails and lock comes from the aligned run.
    test_id = 4;
    hold_reset(2);
    send_rep(8'h5E, 1);
    send_rep(8'h00, 1);
    send_rep(8'hBC, 3);
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
    send_byte(8'h11, 1'b1, 8'h11, 1'b1);

    test_id = 5;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk32f);
    reset   = 1'b0;
    in      = 1'b1;
    cur_act = 1'b0;
    cur_out = 8'h00;
    cur_v   = 1'b0;
    push_exp();
    #1;
    checks++;
    if ({active, out, valid_out} !== 10'b0) begin
      failures++;
      $display("FAIL async_reset: got active=%0b out=%02h valid_out=%0b want active=0 out=00 valid_out=0",
               active, out, valid_out);
    end
    hold_reset(2);
    send_rep(8'hAA, 1);
    send_rep(8'hBC, 3);
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
    send_byte(8'h22, 1'b1, 8'h22, 1'b1);

    repeat (3) @(posedge clk32f);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got pending=%0d want pending=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
